// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit:
// execute op kinds, trap causes, branch funct3 codes and FSM states.
package pc_pkg;

  typedef enum logic [1:0] {
    K_SEQ    = 2'd0,
    K_JAL    = 2'd1,
    K_JALR   = 2'd2,
    K_BRANCH = 2'd3
  } kind_e;

  localparam logic [1:0] C_NONE    = 2'd0;
  localparam logic [1:0] C_MISALGN = 2'd1;
  localparam logic [1:0] C_ILLBR   = 2'd2;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_TRAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pc_unit_branch_cmp.sv
// Branch condition evaluator: funct3 plus operands
// give taken, or flag the two reserved encodings.
module branch_cmp
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) < $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 < rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC owner: resolves jumps/branches from execute,
// writes link values, redirects fetch and raises precise traps.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          IALIGN       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      ex_kind,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic            redirect,
  output logic            rd_we,
  output logic [XLEN-1:0] rd_val,
  output logic            trap_valid,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] trap_tval,
  input  logic            trap_ack
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  state_e          state, state_n;
  logic [CW-1:0]   cnt;
  kind_e           kind;
  logic            acc, br_taken, br_ill;
  logic            take, link, ill, mis, jump;
  logic [XLEN-1:0] tgt;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3  (ex_funct3),
    .rs1     (ex_rs1),
    .rs2     (ex_rs2),
    .taken   (br_taken),
    .illegal (br_ill)
  );

  assign kind     = kind_e'(ex_kind);
  assign ex_ready = (state == S_RUN) & ~stall & ~rst;
  assign acc      = ex_valid & ex_ready;

  always_comb begin
    tgt  = '0;
    take = 1'b0;
    link = 1'b0;
    unique case (kind)
      K_JAL: begin
        tgt  = ex_pc + ex_imm;
        take = 1'b1;
        link = 1'b1;
      end
      K_JALR: begin
        tgt  = (ex_rs1 + ex_imm) & ~XLEN'(1);
        take = 1'b1;
        link = 1'b1;
      end
      K_BRANCH: begin
        tgt  = ex_pc + ex_imm;
        take = br_taken & ~br_ill;
      end
      default: ;
    endcase
  end

  assign ill  = acc & (kind == K_BRANCH) & br_ill;
  assign mis  = acc & take & (|(tgt & XLEN'(IALIGN - 1)));
  assign jump = acc & take & ~mis;

  always_comb begin
    state_n = state;
    unique case (state)
      S_RUN: begin
        if (ill | mis)
          state_n = S_TRAP;
        else if (jump && FLUSH_CYCLES != 0)
          state_n = S_FLUSH;
      end
      S_FLUSH: if (cnt <= CW'(1)) state_n = S_RUN;
      S_TRAP:  if (trap_ack) state_n = S_RUN;
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      cnt         <= '0;
      fetch_pc    <= XLEN'(RESET_VECTOR);
      fetch_valid <= 1'b0;
      redirect    <= 1'b0;
      rd_we       <= 1'b0;
      rd_val      <= '0;
      trap_valid  <= 1'b0;
      trap_cause  <= C_NONE;
      trap_tval   <= '0;
    end else begin
      state       <= state_n;
      fetch_valid <= (state_n == S_RUN);
      redirect    <= 1'b0;
      rd_we       <= 1'b0;
      if (state == S_FLUSH)
        cnt <= cnt - CW'(1);
      // Redirects take priority over the sequential fetch advance.
      if (ill | mis) begin
        fetch_pc   <= XLEN'(TRAP_VECTOR);
        redirect   <= 1'b1;
        trap_valid <= 1'b1;
        trap_cause <= ill ? C_ILLBR : C_MISALGN;
        trap_tval  <= ill ? ex_pc : tgt;
      end else if (jump) begin
        fetch_pc <= tgt;
        redirect <= 1'b1;
        rd_we    <= link;
        cnt      <= CW'(FLUSH_CYCLES);
        if (link)
          rd_val <= ex_pc + XLEN'(4);
      end else if (fetch_valid & fetch_ready & ~stall) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (state == S_TRAP && trap_ack) begin
        trap_valid <= 1'b0;
        trap_cause <= C_NONE;
        trap_tval  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table,
// hand sequences for reset/flush/wrap, randomized ops vs model.
module tb_pc_unit;

  typedef struct {
    int          res;
    logic [31:0] tgt;
    logic [1:0]  cause;
    logic [31:0] tval;
    bit          link;
    logic [31:0] rdval;
  } exp_t;

  typedef struct {
    int          kind;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    exp_t        e;
  } vec_t;

  localparam logic [31:0] TRAPV = 32'h0000_0100;
  localparam int          FLUSH = 2;

  logic        clk = 0;
  logic        rst, stall, ex_valid, ex_ready;
  logic [1:0]  ex_kind;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [31:0] fetch_pc;
  logic        fetch_valid, fetch_ready, redirect, rd_we;
  logic [31:0] rd_val;
  logic        trap_valid;
  logic [1:0]  trap_cause;
  logic [31:0] trap_tval;
  logic        trap_ack;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;

  pc_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_kind     (ex_kind),
    .ex_funct3   (ex_funct3),
    .ex_pc       (ex_pc),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_imm      (ex_imm),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .redirect    (redirect),
    .rd_we       (rd_we),
    .rd_val      (rd_val),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_tval   (trap_tval),
    .trap_ack    (trap_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, x);
    end
  endtask

  function automatic exp_t ref_op(input int kind, input logic [2:0] f3,
                                  input logic [31:0] pc, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm);
    exp_t        e;
    logic [31:0] t;
    bit          taken;
    e = '{res: 0, tgt: 0, cause: 0, tval: 0, link: 0, rdval: 0};
    taken = 0;
    t = pc + imm;
    if (kind == 1) begin
      taken = 1;
    end else if (kind == 2) begin
      t = (rs1 + imm) & 32'hFFFF_FFFE;
      taken = 1;
    end else if (kind == 3) begin
      if (f3 == 3'd2 || f3 == 3'd3) begin
        e.res = 2; e.cause = 2; e.tval = pc;
        return e;
      end
      case (f3)
        3'd0: taken = (rs1 == rs2);
        3'd1: taken = (rs1 != rs2);
        3'd4: taken = ($signed(rs1) < $signed(rs2));
        3'd5: taken = ($signed(rs1) >= $signed(rs2));
        3'd6: taken = (rs1 < rs2);
        default: taken = (rs1 >= rs2);
      endcase
    end
    if (!taken) return e;
    if (t % 4 != 0) begin
      e.res = 2; e.cause = 1; e.tval = t;
      return e;
    end
    e.res = 1;
    e.tgt = t;
    e.link = (kind != 3);
    e.rdval = pc + 4;
    return e;
  endfunction

  task automatic recover(input int res);
    if (res == 2) begin
      step();
      chk("trap_hold", trap_valid, 1);
      chk("redir_pulse", redirect, 0);
      trap_ack = 1;
      step();
      trap_ack = 0;
      chk("trap_clr", trap_valid, 0);
      chk("cause_clr", trap_cause, 0);
      chk("fv_after_ack", fetch_valid, 1);
      chk("pc_after_ack", fetch_pc, m_pc);
    end else if (res == 1) begin
      chk("fv_flush0", fetch_valid, 0);
      for (int i = 1; i < FLUSH; i++) begin
        step();
        chk("fv_flush", fetch_valid, 0);
        chk("rdwe_pulse", rd_we, 0);
      end
      step();
      chk("fv_resume", fetch_valid, 1);
      chk("pc_resume", fetch_pc, m_pc);
    end
  endtask

  task automatic do_op(input int kind, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input bit rdy, input bit stl, input exp_t e);
    int res;
    ex_kind = 2'(kind); ex_funct3 = f3; ex_pc = pc;
    ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm;
    ex_valid = 1; fetch_ready = rdy; stall = stl;
    #1;
    chk("ex_ready", ex_ready, {31'd0, !stl});
    step();
    ex_valid = 0; fetch_ready = 0; stall = 0;
    res = stl ? 0 : e.res;
    if (res == 2) m_pc = TRAPV;
    else if (res == 1) m_pc = e.tgt;
    else if (rdy && !stl) m_pc = m_pc + 4;
    chk("fetch_pc", fetch_pc, m_pc);
    chk("redirect", redirect, {31'd0, res != 0});
    chk("rd_we", rd_we, {31'd0, res == 1 && e.link});
    if (res == 1 && e.link) chk("rd_val", rd_val, e.rdval);
    chk("trap_valid", trap_valid, {31'd0, res == 2});
    if (res == 2) begin
      chk("trap_cause", trap_cause, e.cause);
      chk("trap_tval", trap_tval, e.tval);
    end
    recover(res);
  endtask

  vec_t vecs[13];
  exp_t e;

  initial begin
    vecs[0]  = '{1, 3'd0, 32'h40, 0, 0, 32'h20, '{1, 32'h60, 2'd0, 0, 1, 32'h44}};
    vecs[1]  = '{2, 3'd0, 32'h10, 32'h1001, 0, 32'h2, '{2, 0, 2'd1, 32'h1002, 0, 0}};
    vecs[2]  = '{3, 3'd4, 32'h100, 32'hFFFF_FFFF, 1, 32'h10, '{1, 32'h110, 2'd0, 0, 0, 0}};
    vecs[3]  = '{3, 3'd6, 32'h100, 32'hFFFF_FFFF, 1, 32'h10, '{0, 0, 2'd0, 0, 0, 0}};
    vecs[4]  = '{3, 3'd2, 32'h80, 0, 0, 32'h8, '{2, 0, 2'd2, 32'h80, 0, 0}};
    vecs[5]  = '{2, 3'd0, 32'h10, 32'h2001, 0, 32'h3, '{1, 32'h2004, 2'd0, 0, 1, 32'h14}};
    vecs[6]  = '{3, 3'd0, 32'h200, 7, 7, 32'hFFFF_FFF0, '{1, 32'h1F0, 2'd0, 0, 0, 0}};
    vecs[7]  = '{3, 3'd1, 32'h200, 7, 7, 32'h40, '{0, 0, 2'd0, 0, 0, 0}};
    vecs[8]  = '{3, 3'd5, 32'h300, 32'h8000_0000, 0, 32'h8, '{0, 0, 2'd0, 0, 0, 0}};
    vecs[9]  = '{3, 3'd7, 32'h300, 32'h8000_0000, 0, 32'h6, '{2, 0, 2'd1, 32'h306, 0, 0}};
    vecs[10] = '{0, 3'd0, 32'h400, 0, 0, 32'h40, '{0, 0, 2'd0, 0, 0, 0}};
    vecs[11] = '{3, 3'd3, 32'h84, 0, 0, 32'h8, '{2, 0, 2'd2, 32'h84, 0, 0}};
    vecs[12] = '{1, 3'd0, 32'hFFFF_FFF0, 0, 0, 32'h20, '{1, 32'h10, 2'd0, 0, 1, 32'hFFFF_FFF4}};

    rst = 1; stall = 0; ex_valid = 0; ex_kind = 0; ex_funct3 = 0;
    ex_pc = 0; ex_rs1 = 0; ex_rs2 = 0; ex_imm = 0;
    fetch_ready = 0; trap_ack = 0;
    step();
    step();
    chk("rst_pc", fetch_pc, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_exr", ex_ready, 0);
    chk("rst_redir", redirect, 0);
    chk("rst_trap", trap_valid, 0);
    chk("rst_rdval", rd_val, 0);
    rst = 0;
    step();
    chk("fv_first", fetch_valid, 1);
    chk("pc_first", fetch_pc, 0);
    fetch_ready = 1;
    step(); chk("seq_4", fetch_pc, 32'h4);
    step(); chk("seq_8", fetch_pc, 32'h8);
    step(); chk("seq_c", fetch_pc, 32'hC);
    fetch_ready = 0;
    m_pc = 32'hC;

    for (int i = 0; i < 13; i++)
      do_op(vecs[i].kind, vecs[i].f3, vecs[i].pc, vecs[i].rs1,
            vecs[i].rs2, vecs[i].imm, 0, 0, vecs[i].e);

    // reset while a trap is pending
    ex_kind = 2'd3; ex_funct3 = 3'd2; ex_pc = 32'h80; ex_valid = 1;
    step();
    ex_valid = 0;
    chk("ill_cause", trap_cause, 2);
    chk("ill_tval", trap_tval, 32'h80);
    rst = 1;
    step();
    chk("rst_trap_pc", fetch_pc, 0);
    chk("rst_trap_tv", trap_valid, 0);
    chk("rst_trap_fv", fetch_valid, 0);
    rst = 0;
    step();
    chk("rst_trap_run", fetch_valid, 1);
    m_pc = 0;

    // reset mid-flush
    ex_kind = 2'd1; ex_pc = 32'h40; ex_imm = 32'h20; ex_valid = 1;
    step();
    ex_valid = 0;
    rst = 1;
    step();
    chk("rst_fl_pc", fetch_pc, 0);
    chk("rst_fl_rdwe", rd_we, 0);
    chk("rst_fl_redir", redirect, 0);
    rst = 0;
    step();
    chk("rst_fl_fv", fetch_valid, 1);

    // wrap and redirect-vs-handshake priority
    do_op(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, ref_op(1, 0, 0, 0, 0, 32'hFFFF_FFFC));
    do_op(0, 0, 0, 0, 0, 0, 1, 0, ref_op(0, 0, 0, 0, 0, 0));
    chk("wrap_zero", fetch_pc, 0);
    do_op(3, 0, 32'h100, 5, 5, 32'h100, 1, 0, ref_op(3, 0, 32'h100, 5, 5, 32'h100));
    chk("beq_wins", fetch_pc, 32'h200);

    // stall: blocks acceptance, freezes pc, flush counter keeps running
    do_op(1, 0, 32'h500, 0, 0, 32'h100, 1, 1, ref_op(1, 0, 32'h500, 0, 0, 32'h100));
    ex_kind = 2'd1; ex_pc = 32'h500; ex_imm = 32'h100; ex_valid = 1;
    step();
    ex_valid = 0;
    chk("st_redir", redirect, 1);
    stall = 1; fetch_ready = 1;
    step(); chk("st_fl", fetch_valid, 0);
    step(); chk("st_fv", fetch_valid, 1);
    chk("st_pc0", fetch_pc, 32'h600);
    step(); chk("st_freeze", fetch_pc, 32'h600);
    stall = 0;
    step(); chk("st_go", fetch_pc, 32'h604);
    fetch_ready = 0;
    m_pc = 32'h604;

    for (int n = 0; n < 300; n++) begin
      int          k;
      logic [2:0]  f;
      logic [31:0] p, a, b, im;
      logic [12:0] t;
      bit          rdy, stl;
      k = int'($urandom_range(0, 3));
      f = 3'($urandom);
      p = $urandom & 32'hFFFF_FFFC;
      a = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
      b = $urandom_range(0, 2) == 0 ? a : $urandom;
      t = 13'($urandom);
      if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
      im = {{19{t[12]}}, t};
      rdy = 1'($urandom);
      stl = ($urandom_range(0, 5) == 0);
      e = ref_op(k, f, p, a, b, im);
      do_op(k, f, p, a, b, im, rdy, stl, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
